// File: rtl/usr_nbit_framed.sv
// Parametrised universal shift register with clock enable, registered serial
// output and a frame counter that strobes after every WIDTH shift/rotate ops.
module usr_nbit_framed #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHR   = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTR  = 3'b100,
    MODE_ROTL  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] data_nxt;
  logic             ser_nxt;
  logic             is_shift;
  logic             is_restart;

  always_comb begin
    data_nxt   = data_out;
    ser_nxt    = serial_out;
    is_shift   = 1'b0;
    is_restart = 1'b0;
    case (mode_e'(mode))
      MODE_SHR: begin
        data_nxt = {serial_in, data_out[WIDTH-1:1]};
        ser_nxt  = data_out[0];
        is_shift = 1'b1;
      end
      MODE_SHL: begin
        data_nxt = {data_out[WIDTH-2:0], serial_in};
        ser_nxt  = data_out[WIDTH-1];
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        data_nxt   = data_in;
        ser_nxt    = 1'b0;
        is_restart = 1'b1;
      end
      MODE_ROTR: begin
        data_nxt = {data_out[0], data_out[WIDTH-1:1]};
        ser_nxt  = data_out[0];
        is_shift = 1'b1;
      end
      MODE_ROTL: begin
        data_nxt = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        ser_nxt  = data_out[WIDTH-1];
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        data_nxt = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        ser_nxt  = data_out[0];
        is_shift = 1'b1;
      end
      MODE_CLEAR: begin
        data_nxt   = '0;
        ser_nxt    = 1'b0;
        is_restart = 1'b1;
      end
      default: ;
    endcase
  end

  // Single register stage: every output updates on the edge that samples the op
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      serial_out <= 1'b0;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (en) begin
        data_out   <= data_nxt;
        serial_out <= ser_nxt;
        if (is_restart) begin
          shift_cnt <= '0;
        end else if (is_shift) begin
          if (shift_cnt == CNT_LAST) begin
            shift_cnt  <= '0;
            frame_done <= 1'b1;
          end else begin
            shift_cnt <= shift_cnt + CNT_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_usr_nbit_framed.sv
// Directed bench for usr_nbit_framed: arithmetic reference model checked every
// cycle, plus literal expectations taken from worked examples.
module tb_usr_nbit_framed;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  data_in = '0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  data_out;
  logic          serial_out;
  logic [CW-1:0] shift_cnt;
  logic          frame_done;

  usr_nbit_framed #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .serial_in(serial_in), .data_out(data_out), .serial_out(serial_out),
    .shift_cnt(shift_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  // Reference state
  logic [W-1:0] m_data = '0;
  bit           m_ser  = 1'b0;
  int           m_cnt  = 0;
  bit           m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input logic [2:0] md,
                            input logic [W-1:0] din, input bit si);
    bit shifted = 1'b0;
    if (r) begin
      m_data = '0; m_ser = 1'b0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (e) begin
        case (md)
          3'd1: begin m_ser = m_data[0];   m_data = (m_data >> 1) | (W'(si) << (W-1)); shifted = 1'b1; end
          3'd2: begin m_ser = m_data[W-1]; m_data = (m_data << 1) | W'(si);            shifted = 1'b1; end
          3'd3: begin m_ser = 1'b0; m_data = din; m_cnt = 0; end
          3'd4: begin m_ser = m_data[0];   m_data = (m_data >> 1) | (m_data << (W-1)); shifted = 1'b1; end
          3'd5: begin m_ser = m_data[W-1]; m_data = (m_data << 1) | (m_data >> (W-1)); shifted = 1'b1; end
          3'd6: begin m_ser = m_data[0];   m_data = W'($signed(m_data) >>> 1);         shifted = 1'b1; end
          3'd7: begin m_ser = 1'b0; m_data = '0; m_cnt = 0; end
          default: ;
        endcase
        if (shifted) begin
          m_cnt = (m_cnt + 1) % W;
          if (m_cnt == 0) m_done = 1'b1;
        end
      end
    end
  endtask

  // Apply one operation across one rising edge; returns 1 ns after the edge
  task automatic op(input bit r, input bit e, input logic [2:0] md,
                    input logic [W-1:0] din = '0, input bit si = 1'b0);
    rst = r; en = e; mode = md; data_in = din; serial_in = si;
    @(posedge clk);
    model_step(r, e, md, din, si);
    cmp_on = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_data", data_out, m_data);
      chk("model_ser", serial_out, m_ser);
      chk("model_cnt", shift_cnt, m_cnt);
      chk("model_done", frame_done, m_done);
    end
  end

  initial begin
    @(negedge clk);
    // Reset dominates a concurrent load
    op(1, 1, 3'd3, 8'hFF);
    op(1, 1, 3'd3, 8'hFF);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ser", serial_out, 0);
    chk("rst_cnt", shift_cnt, 0);
    chk("rst_done", frame_done, 0);
    op(0, 1, 3'd3, 8'hA5);
    chk("load_a5", data_out, 8'hA5);

    op(0, 1, 3'd1, '0, 1'b1);
    chk("shr_data", data_out, 8'hD2);
    chk("shr_ser", serial_out, 1);
    op(0, 1, 3'd3, 8'hA5);
    chk("load_ser0", serial_out, 0);
    op(0, 1, 3'd2, '0, 1'b0);
    chk("shl_data", data_out, 8'h4A);
    chk("shl_ser", serial_out, 1);

    op(0, 1, 3'd3, 8'h81);
    op(0, 1, 3'd4);
    chk("rotr_data", data_out, 8'hC0);
    op(0, 1, 3'd3, 8'h81);
    op(0, 1, 3'd5);
    chk("rotl_data", data_out, 8'h03);
    op(0, 1, 3'd3, 8'h80);
    op(0, 1, 3'd6, '0, 1'b0);
    chk("asr_neg", data_out, 8'hC0);
    op(0, 1, 3'd3, 8'h40);
    op(0, 1, 3'd6, '0, 1'b1);
    chk("asr_pos", data_out, 8'h20);

    // Full frame of rotates
    op(0, 1, 3'd3, 8'h3C);
    for (int i = 1; i <= W; i++) begin
      op(0, 1, 3'd4);
      chk("frame_cnt", shift_cnt, i % W);
      chk("frame_done", frame_done, (i == W) ? 1 : 0);
    end
    chk("frame_data", data_out, 8'h3C);
    op(0, 1, 3'd0);
    chk("frame_done_clr", frame_done, 0);

    // Pause: en low and hold keep the count
    op(0, 1, 3'd3, 8'h5A);
    for (int i = 0; i < 3; i++) op(0, 1, 3'd2, '0, 1'b1);
    chk("pause_cnt3", shift_cnt, 3);
    op(0, 0, 3'd1, '0, 1'b1);
    op(0, 0, 3'd2, '0, 1'b0);
    chk("pause_en0", shift_cnt, 3);
    op(0, 1, 3'd0);
    chk("pause_hold", shift_cnt, 3);
    for (int i = 1; i <= 5; i++) begin
      op(0, 1, 3'd1, '0, 1'b0);
      chk("pause_done", frame_done, (i == 5) ? 1 : 0);
    end
    chk("pause_wrap", shift_cnt, 0);

    // Restart by CLEAR
    op(0, 1, 3'd3, 8'hF0);
    for (int i = 0; i < 6; i++) op(0, 1, 3'd1, '0, 1'b1);
    op(0, 1, 3'd7);
    chk("clr_data", data_out, 8'h00);
    chk("clr_cnt", shift_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      op(0, 1, 3'd1, '0, 1'b0);
      chk("clr_nodone", frame_done, 0);
    end
    chk("clr_cnt2", shift_cnt, 2);

    // Restart by reset mid-frame
    op(0, 1, 3'd3, 8'hF0);
    for (int i = 0; i < 6; i++) op(0, 1, 3'd1, '0, 1'b1);
    op(1, 1, 3'd1, '0, 1'b1);
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_ser", serial_out, 0);
    chk("mrst_cnt", shift_cnt, 0);
    chk("mrst_done", frame_done, 0);

    // Frame completes, then LOAD: pulse stays one cycle, count restarts
    op(0, 1, 3'd3, 8'h01);
    for (int i = 0; i < W; i++) op(0, 1, 3'd5);
    chk("wrap_done", frame_done, 1);
    op(0, 1, 3'd3, 8'h77);
    chk("load_after_wrap", frame_done, 0);
    op(0, 1, 3'd6);
    chk("cnt_after_load", shift_cnt, 1);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/usr_nbit_framed.md
Name: usr_nbit_framed

Overview:
Parametrised universal shift register, successor to the fixed 4-bit USR. Generalised to WIDTH bits and extended to an 8-mode operation set:
- hold, logical shifts, parallel load, rotates, arithmetic shift right, clear.

Adds a clock enable, a registered serial output and a shift-frame counter that strobes after every WIDTH consecutive shift/rotate operations. Used as the serialiser/deserialiser and bit-manipulation register in the datapath.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), width of shift_cnt; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
en  input  1  operation enable; when low, all state holds.
mode  input  3  operation select, sampled on the clk edge when en=1.
data_in  input  WIDTH  parallel load value.
serial_in  input  1  serial bit entering on logical shifts.
data_out  output  WIDTH  register contents.
serial_out  output  1  bit ejected by the most recent shift/rotate.
shift_cnt  output  CNT_W  shift/rotate ops since last load/clear/frame wrap.
frame_done  output  1  one-cycle strobe on frame completion.

Behaviour:
Reset and enable priority:
- rst=1 at a clk edge: data_out=0, serial_out=0, shift_cnt=0, frame_done=0.
- rst has priority over en and mode.
- rst asserted mid-frame discards the partial frame.
- en=0: data_out, serial_out and shift_cnt hold; frame_done=0.
- All outputs are registered. Each operation takes effect on the edge where it is sampled (latency 1).

Modes (en=1, D = data_out before the edge):
- 000 hold: D unchanged; shift_cnt unchanged; serial_out unchanged.
- 001 SHR: {serial_in, D[WIDTH-1:1]}; serial_out=D[0].
- 010 SHL: {D[WIDTH-2:0], serial_in}; serial_out=D[WIDTH-1].
- 011 LOAD: data_in; serial_out=0; shift_cnt=0.
- 100 ROTR: {D[0], D[WIDTH-1:1]}; serial_out=D[0].
- 101 ROTL: {D[WIDTH-2:0], D[WIDTH-1]}; serial_out=D[WIDTH-1].
- 110 ASR: {D[WIDTH-1], D[WIDTH-1:1]}; serial_out=D[0]; serial_in ignored.
- 111 CLEAR: all zeros; serial_out=0; shift_cnt=0.

Frame counter:
- Modes 001, 010, 100, 101 and 110 are shift ops.
- Each shift op increments shift_cnt.
- On the shift op where shift_cnt==WIDTH-1: shift_cnt wraps to 0 and frame_done=1 for the following cycle only.
- frame_done=0 after every other edge, including hold, load and clear.
- Hold and en=0 do not break a frame; the count resumes on the next shift op.
- Mixing directions within a frame is legal; every shift op counts.
- LOAD or CLEAR on any cycle restarts the frame. If the prior op completed a frame, frame_done still pulses for that one cycle.

Width rules:
- No arithmetic beyond the counter increment.
- The counter never exceeds WIDTH-1.

Test Plan:
- Reset behaviour, WIDTH=8: assert rst for 2 cycles with en=1, mode=011, data_in=8'hFF. Required: data_out=8'h00, serial_out=0, shift_cnt=0, frame_done=0. Then rst=0, LOAD 8'hA5 gives data_out=8'hA5 one edge later.
- Logical shifts: from 8'hA5, SHR with serial_in=1 gives 8'hD2, serial_out=1. Reload 8'hA5, then SHL with serial_in=0 gives 8'h4A, serial_out=1.
- Rotate and ASR: from 8'h81, ROTR gives 8'hC0 and ROTL gives 8'h03. ASR from 8'h80 gives 8'hC0; ASR from 8'h40 gives 8'h20.
- Frame completion: LOAD 8'h3C, then 8 consecutive ROTR. Required:
  - shift_cnt steps 1..7 then 0;
  - data_out returns to 8'h3C;
  - frame_done high for exactly the cycle after the 8th ROTR.
- Frame pausing: LOAD, 3×SHL, then en=0 for 2 cycles, HOLD for 1 cycle, then 5×SHR. Required: shift_cnt holds at 3 through the pause; frame_done pulses only after the 5th SHR.
- Frame restart: LOAD, 6×SHR, CLEAR, 2×SHR. Required: data_out=0 after CLEAR, shift_cnt=2, no frame_done. Repeat with rst instead of CLEAR at cycle 6: all outputs are zero next cycle.
